ahb_timer_slave: RTL

//  AHB-Lite responder (slave) holding a 64-bit machine timer with compare interrupt.

---
 rtl/ahb_timer_slave_pkg.sv | 46 ++++
 rtl/ahb_timer_slave_if.sv | 29 ++
 rtl/ahb_timer_slave_timer_counter.sv | 94 +++++++++
 rtl/ahb_timer_slave.sv | 109 ++++++++++
 4 files changed

// File: rtl/ahb_timer_slave_pkg.sv
// Shared AHB-Lite constants, register map and FSM state type
// for the memory-mapped machine timer responder.
package ahb_timer_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;
   localparam logic [2:0] OFF_PRESCALE = 3'd6;
   localparam logic [2:0] OFF_UNMAPPED = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_e;

   function automatic logic is_legal(
      input logic [2:0] off,
      input logic [2:0] size,
      input logic [1:0] lsb
   );
      return (off != OFF_UNMAPPED) &&
             (size == HSIZE_WORD) &&
             (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/ahb_timer_slave_if.sv
// AHB-Lite bus bundle between the interconnect and the
// timer responder.
interface ahb_timer_slave_if;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready_in;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize,
      output hprot, hwdata, hready_in,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize,
      input  hprot, hwdata, hready_in,
      output hrdata, hready, hresp
   );

endinterface

// File: rtl/ahb_timer_slave_timer_counter.sv
// Prescaler, 64-bit mtime, compare and sticky pending flag,
// plus the register file read mux for the timer.
module timer_counter
   import ahb_timer_slave_pkg::*;
#(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_off,
   input  logic [31:0] wdata,
   input  logic [2:0]  rd_off,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

   logic [63:0]        mtime;
   logic [63:0]        mtimecmp;
   logic [63:0]        mtime_nxt;
   logic [63:0]        cmp_nxt;
   logic [PRESC_W-1:0] prescale;
   logic [PRESC_W-1:0] presc_cnt;
   logic               en;
   logic               irq_en;
   logic               pending;
   logic               pend_nxt;
   logic               tick;
   logic               w1c;

   assign tick = en & (presc_cnt == prescale);
   assign w1c  = wr_en & (wr_off == OFF_STATUS) & wdata[0];

   // Next time/compare values; a bus write replaces the tick.
   always_comb begin
      mtime_nxt = tick ? mtime + 64'd1 : mtime;
      cmp_nxt   = mtimecmp;
      if (wr_en) begin
         case (wr_off)
            OFF_MTIME_LO: mtime_nxt = {mtime[63:32], wdata};
            OFF_MTIME_HI: mtime_nxt = {wdata, mtime[31:0]};
            OFF_CMP_LO:   cmp_nxt   = {mtimecmp[63:32], wdata};
            OFF_CMP_HI:   cmp_nxt   = {wdata, mtimecmp[31:0]};
            default: ;
         endcase
      end
      pend_nxt = (mtime_nxt >= cmp_nxt) | (pending & ~w1c);
   end

   // Timer state; compare set wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         prescale  <= '0;
         presc_cnt <= '0;
         en        <= 1'b0;
         irq_en    <= 1'b0;
         pending   <= 1'b0;
         irq       <= 1'b0;
      end else begin
         mtime    <= mtime_nxt;
         mtimecmp <= cmp_nxt;
         pending  <= pend_nxt;
         irq      <= pending & irq_en;
         if (en)
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_ONE;
         if (wr_en && wr_off == OFF_CTRL) begin
            en     <= wdata[0];
            irq_en <= wdata[1];
         end
         if (wr_en && wr_off == OFF_PRESCALE)
            prescale <= wdata[PRESC_W-1:0];
      end
   end

   // Register read mux; the unmapped slot reads zero.
   always_comb begin
      rdata = '0;
      case (rd_off)
         OFF_MTIME_LO: rdata = mtime[31:0];
         OFF_MTIME_HI: rdata = mtime[63:32];
         OFF_CMP_LO:   rdata = mtimecmp[31:0];
         OFF_CMP_HI:   rdata = mtimecmp[63:32];
         OFF_CTRL:     rdata = {30'd0, irq_en, en};
         OFF_STATUS:   rdata = {31'd0, pending};
         OFF_PRESCALE: rdata = 32'(prescale);
         default:      rdata = '0;
      endcase
   end

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB-Lite responder for the machine timer: data-phase
// registers and the wait/error FSM in front of timer_counter.
module ahb_timer_slave
   import ahb_timer_slave_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int PRESC_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   ahb_timer_slave_if.slave bus,
   output logic             irq
);

   localparam logic [1:0] WS_LAST =
      (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   state_e      state;
   logic [1:0]  wait_cnt;
   logic [2:0]  dp_off;
   logic        dp_write;
   logic        hready_q;
   hresp_e      hresp_q;
   logic        accept;
   logic        legal;
   logic        wr_en;
   logic        rd_done;
   logic [31:0] rdata;
   logic        unused_bits;

   assign accept  = bus.hsel & bus.hready_in & bus.htrans[1];
   assign legal   = is_legal(bus.haddr[4:2], bus.hsize,
                             bus.haddr[1:0]);
   assign wr_en   = (state == ST_DONE) & dp_write;
   assign rd_done = (state == ST_DONE) & ~dp_write;

   assign bus.hready = hready_q;
   assign bus.hresp  = hresp_q;
   assign bus.hrdata = rd_done ? rdata : 32'd0;

   assign unused_bits = ^{bus.hprot, bus.haddr[31:5],
                          bus.htrans[0]};

   // Data-phase FSM; new address taken whenever bus is free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         dp_off   <= '0;
         dp_write <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
      end else begin
         unique case (state)
            ST_WAIT: begin
               if (wait_cnt == 2'd0) begin
                  state    <= ST_DONE;
                  hready_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            ST_ERR1: begin
               state    <= ST_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_ERROR;
            end
            default: begin
               if (accept) begin
                  dp_off   <= bus.haddr[4:2];
                  dp_write <= bus.hwrite;
                  if (!legal) begin
                     state    <= ST_ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_ERROR;
                  end else if (WAIT_STATES > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WS_LAST;
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_OKAY;
                  end else begin
                     state    <= ST_DONE;
                     hready_q <= 1'b1;
                     hresp_q  <= HRESP_OKAY;
                  end
               end else begin
                  state    <= ST_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   timer_counter #(
      .PRESC_W (PRESC_W)
   ) u_counter (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_off (dp_off),
      .wdata  (bus.hwdata),
      .rd_off (dp_off),
      .rdata  (rdata),
      .irq    (irq)
   );

endmodule
